// File: rtl/branch_cmp_pkg.sv
// branch_cmp_pkg
// Shared types for the iterative branch-condition evaluator:
//   cond_e     - condition codes (beq/bne, signed zero compares, movz/movn)
//   state_e    - evaluator FSM states
//   rel_e      - final relation of operand A against operand B
//   cond_taken - maps a condition code and a relation to the taken flag
package branch_cmp_pkg;

    typedef enum logic [2:0] {
        COND_EQ   = 3'd0,
        COND_NE   = 3'd1,
        COND_LEZ  = 3'd2,
        COND_GTZ  = 3'd3,
        COND_LTZ  = 3'd4,
        COND_GEZ  = 3'd5,
        COND_MOVZ = 3'd6,
        COND_MOVN = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        REL_LT = 2'd0,
        REL_EQ = 2'd1,
        REL_GT = 2'd2
    } rel_e;

    function automatic logic cond_taken(input cond_e c, input rel_e r);
        logic t;
        case (c)
            COND_EQ, COND_MOVZ: t = (r == REL_EQ);
            COND_NE, COND_MOVN: t = (r != REL_EQ);
            COND_LEZ:           t = (r != REL_GT);
            COND_GTZ:           t = (r == REL_GT);
            COND_LTZ:           t = (r == REL_LT);
            COND_GEZ:           t = (r != REL_LT);
            default:            t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_cmp_chunk.sv
// branch_cmp_chunk
// Combinational CHUNK-wide magnitude compare of a against b.
// Ports:
//   a, b       in  CHUNK  operand slices
//   is_signed  in  1      treat slices as two's complement (MSB chunk only)
//   eq, gt, lt out 1      a == b, a > b, a < b
module branch_cmp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             is_signed,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    logic signed [CHUNK-1:0] a_s;
    logic signed [CHUNK-1:0] b_s;

    assign a_s = a;
    assign b_s = b;

    assign eq = (a == b);
    assign gt = is_signed ? (a_s > b_s) : (a > b);
    assign lt = is_signed ? (a_s < b_s) : (a < b);

endmodule

// File: rtl/branch_cmp_iter.sv
// branch_cmp_iter
// Iterative branch-condition evaluator. Operands are compared CHUNK bits per
// cycle from the MSB chunk (signed) down to chunk 0 (unsigned); the scan stops
// on the first differing chunk, and the relation is decoded to a taken flag
// according to the latched condition code.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (cond, rs_data, rt_data)
//   flush                 synchronous abort, highest priority
//   out_valid / out_ready result handshake, taken is the result
//   dbg_state             current FSM state
//   stat_total/stat_taken saturating handshake counters, present only when
//                         BRANCH_CMP_STATS_EN is defined
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE and
// stays high, with taken stable, until out_ready is sampled high. A flush in
// the same cycle overrides either transfer.
module branch_cmp_iter
    import branch_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       cond,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output state_e           dbg_state
`ifdef BRANCH_CMP_STATS_EN
    ,
    output logic [31:0]      stat_total,
    output logic [31:0]      stat_taken
`endif
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    cond_e            cond_q, cond_d;
    logic             taken_q, taken_d;

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic             c_eq, c_gt, c_lt;
    rel_e             rel;

    assign a_slice = a_q[idx_q*CHUNK +: CHUNK];
    assign b_slice = b_q[idx_q*CHUNK +: CHUNK];

    branch_cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a         (a_slice),
        .b         (b_slice),
        .is_signed (idx_q == IDX_LAST),
        .eq        (c_eq),
        .gt        (c_gt),
        .lt        (c_lt)
    );

    // When the current chunk is equal this is only final on chunk 0, where
    // all chunks have matched.
    always_comb begin
        rel = REL_EQ;
        if (!c_eq) begin
            rel = c_gt ? REL_GT : REL_LT;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        cond_d  = cond_q;
        taken_d = taken_q;

        if (flush) begin
            state_d = S_IDLE;
            idx_d   = IDX_LAST;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_d = S_SCAN;
                        idx_d   = IDX_LAST;
                        cond_d  = cond_e'(cond);
                        case (cond_e'(cond))
                            COND_EQ, COND_NE: begin
                                a_d = rs_data;
                                b_d = rt_data;
                            end
                            COND_MOVZ, COND_MOVN: begin
                                a_d = rt_data;
                                b_d = '0;
                            end
                            default: begin
                                a_d = rs_data;
                                b_d = '0;
                            end
                        endcase
                    end
                end
                S_SCAN: begin
                    if (!c_eq || (idx_q == '0)) begin
                        state_d = S_DONE;
                        taken_d = cond_taken(cond_q, rel);
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= IDX_LAST;
            a_q     <= '0;
            b_q     <= '0;
            cond_q  <= COND_EQ;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cond_q  <= cond_d;
            taken_q <= taken_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign taken     = taken_q;
    assign dbg_state = state_q;

`ifdef BRANCH_CMP_STATS_EN
    logic [31:0] stat_total_q, stat_total_d;
    logic [31:0] stat_taken_q, stat_taken_d;
    logic        done_hs;

    // A result discarded by flush is not a completed handshake.
    assign done_hs = out_valid && out_ready && !flush;

    always_comb begin
        stat_total_d = stat_total_q;
        stat_taken_d = stat_taken_q;
        if (done_hs) begin
            if (stat_total_q != 32'hFFFF_FFFF) begin
                stat_total_d = stat_total_q + 32'd1;
            end
            if (taken_q && (stat_taken_q != 32'hFFFF_FFFF)) begin
                stat_taken_d = stat_taken_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total_q <= '0;
            stat_taken_q <= '0;
        end else begin
            stat_total_q <= stat_total_d;
            stat_taken_q <= stat_taken_d;
        end
    end

    assign stat_total = stat_total_q;
    assign stat_taken = stat_taken_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_branch_cmp_iter.sv
module tb_branch_cmp_iter;
    import branch_cmp_pkg::*;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        cond;
    logic [WIDTH-1:0]  rs_data;
    logic [WIDTH-1:0]  rt_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic              taken;
    state_e            dbg_state;
`ifdef BRANCH_CMP_STATS_EN
    logic [31:0]       stat_total;
    logic [31:0]       stat_taken;
`endif

    int checks   = 0;
    int failures = 0;

    logic [0:0] exp_q[$];

    branch_cmp_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cond      (cond),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .taken     (taken),
        .dbg_state (dbg_state)
`ifdef BRANCH_CMP_STATS_EN
        ,
        .stat_total(stat_total),
        .stat_taken(stat_taken)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one request and wait for its result; the result is left pending.
    task automatic do_req(input string tag, input logic [2:0] c, input logic [31:0] rs,
                          input logic [31:0] rt, input int exp_cycles, input logic exp_taken);
        int cycles;
        logic [0:0] exp_t;
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        exp_q.push_back(exp_taken);
        in_valid = 1'b1;
        cond     = c;
        rs_data  = rs;
        rt_data  = rt;
        @(posedge clk);
        #1;
        // scramble inputs: the unit must use only its latched copies
        in_valid = 1'b0;
        cond     = 3'($urandom_range(0, 7));
        rs_data  = $urandom;
        rt_data  = $urandom;
        cycles = 0;
        while (cycles < 2 * N + 4) begin
            @(posedge clk);
            #1;
            cycles++;
            if (out_valid) break;
        end
        check({tag, "_latency"}, 64'(cycles), 64'(exp_cycles));
        exp_t = exp_q.pop_front();
        check({tag, "_taken"}, {63'd0, taken}, {63'd0, exp_t});
    endtask

    task automatic ack(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ack_ovalid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_ack_iready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        cond      = 3'd0;
        rs_data   = '0;
        rt_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_taken", {63'd0, taken}, 64'd0);
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // full-length equal scan
        do_req("eq_equal", COND_EQ, 32'h1234_5678, 32'h1234_5678, 4, 1'b1);
        ack("eq_equal");
        // MSB chunk decides (0x80 is negative)
        do_req("gtz_neg", COND_GTZ, 32'h8000_0000, 32'h0, 1, 1'b0);
        ack("gtz_neg");
        do_req("lez_neg", COND_LEZ, 32'h8000_0000, 32'h0, 1, 1'b1);
        ack("lez_neg");

        // LSB chunk decides, then hold backpressure
        do_req("ne_lsb", COND_NE, 32'h0000_00FF, 32'h0000_00FE, 4, 1'b1);
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        check("bp_taken", {63'd0, taken}, 64'd1);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        ack("ne_lsb");

        // moves select rt as operand A
        do_req("movz", COND_MOVZ, 32'hDEAD_BEEF, 32'h0, 4, 1'b1);
        ack("movz");
        do_req("movn", COND_MOVN, 32'hDEAD_BEEF, 32'h0, 4, 1'b0);
        ack("movn");

        // further patterns
        do_req("ltz_m1", COND_LTZ, 32'hFFFF_FFFF, 32'h0, 1, 1'b1);
        ack("ltz_m1");
        do_req("gez_one", COND_GEZ, 32'h0000_0001, 32'h0, 4, 1'b1);
        ack("gez_one");
        do_req("eq_chunk2", COND_EQ, 32'h1234_5678, 32'h1235_5678, 2, 1'b0);
        ack("eq_chunk2");
        do_req("gtz_zero", COND_GTZ, 32'h0, 32'hFFFF_FFFF, 4, 1'b0);
        ack("gtz_zero");
        do_req("lez_zero", COND_LEZ, 32'h0, 32'h0, 4, 1'b1);
        ack("lez_zero");

        // flush in the 2nd SCAN cycle together with a new request
        in_valid = 1'b1;
        cond     = COND_NE;
        rs_data  = 32'hAAAA_AAAA;
        rt_data  = 32'hAAAA_AAAA;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        cond     = COND_NE;
        rs_data  = 32'h0100_0000;
        rt_data  = 32'h0;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_state", 64'(dbg_state), 64'(S_IDLE));
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (6) @(posedge clk);
        #1;
        check("flush_no_accept", 64'(dbg_state), 64'(S_IDLE));
        check("flush_no_result", {63'd0, out_valid}, 64'd0);
        check("flush_taken_hold", {63'd0, taken}, 64'd1);
        do_req("post_flush", COND_NE, 32'h0100_0000, 32'h0, 1, 1'b1);
        ack("post_flush");

        // asynchronous reset in the middle of a scan
        in_valid = 1'b1;
        cond     = COND_EQ;
        rs_data  = 32'h5555_5555;
        rt_data  = 32'h5555_5555;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_state", 64'(dbg_state), 64'(S_IDLE));
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check("arst_taken", {63'd0, taken}, 64'd0);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("arst_no_result", {63'd0, out_valid}, 64'd0);

`ifdef BRANCH_CMP_STATS_EN
        check("stat_rst_total", 64'(stat_total), 64'd0);
        do_req("st0", COND_EQ, 32'h7, 32'h7, 4, 1'b1);
        ack("st0");
        do_req("st1", COND_NE, 32'h7, 32'h7, 4, 1'b0);
        ack("st1");
        do_req("st2", COND_GTZ, 32'h0000_0100, 32'h0, 3, 1'b1);
        ack("st2");
        do_req("st3", COND_LTZ, 32'h0000_0100, 32'h0, 3, 1'b0);
        ack("st3");
        do_req("st4", COND_MOVN, 32'h0, 32'h1, 4, 1'b1);
        ack("st4");
        check("stat_total", 64'(stat_total), 64'd5);
        check("stat_taken", 64'(stat_taken), 64'd3);
        force dut.stat_total_q = 32'hFFFF_FFFE;
        force dut.stat_taken_q = 32'hFFFF_FFFE;
        #1;
        release dut.stat_total_q;
        release dut.stat_taken_q;
        do_req("sat0", COND_EQ, 32'h1, 32'h1, 4, 1'b1);
        ack("sat0");
        do_req("sat1", COND_EQ, 32'h1, 32'h1, 4, 1'b1);
        ack("sat1");
        check("stat_total_sat", 64'(stat_total), 64'hFFFF_FFFF);
        check("stat_taken_sat", 64'(stat_taken), 64'hFFFF_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
